// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU (port 0) and a
// debug/loader port (port 1). Each access runs IDLE -> ISSUE -> WAIT -> DONE; all outputs registered.
module dmem_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned MEM_AW  = 10,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [AW-1:0]     addr0,
    input  logic [DW-1:0]     wdata0,
    output logic              ready0,
    output logic [DW-1:0]     rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     wdata1,
    output logic              ready1,
    output logic [DW-1:0]     rdata1,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;  // 1 when port 1 held the most recent grant
    logic              sel_q, sel_d;    // port owning the current access
    logic [1:0]        grant_d;
    logic              busy_d, ready0_d, ready1_d, mem_en_d, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_d;
    logic [DW-1:0]     mem_wdata_d, rdata0_d, rdata1_d;

    // Byte-offset and upper address bits play no part in the word index.
    logic unused_addr;
    assign unused_addr = ^{addr0[AW-1:MEM_AW+2], addr0[1:0], addr1[AW-1:MEM_AW+2], addr1[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        grant_d     = grant;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    sel_d       = (req0 && req1) ? ~last_q : req1;
                    last_d      = sel_d;
                    grant_d     = sel_d ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_d ? we1 : we0;
                    mem_addr_d  = sel_d ? addr1[MEM_AW+1:2] : addr0[MEM_AW+1:2];
                    mem_wdata_d = sel_d ? wdata1 : wdata0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 4'(MEM_LAT);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    if (sel_q) begin
                        rdata1_d = mem_rdata;
                        ready1_d = 1'b1;
                    end else begin
                        rdata0_d = mem_rdata;
                        ready0_d = 1'b1;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            ready0    <= 1'b0;
            ready1    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            grant     <= grant_d;
            busy      <= busy_d;
            ready0    <= ready0_d;
            ready1    <= ready1_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants, issue cycles and
// responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_arbiter;

    localparam int LAT   = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        req0, we0, req1, we1, ready0, ready1, busy, mem_en, mem_we;
    logic [31:0] addr0, wdata0, addr1, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic [1:0]  grant;
    logic [9:0]  mem_addr;

    logic        b_req0, b_ready0, b_ready1, b_busy, b_mem_en, b_mem_we;
    logic [31:0] b_addr0, b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_grant;
    logic [9:0]  b_mem_addr;

    dmem_arbiter #(.MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ready0(ready0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ready1(ready1), .rdata1(rdata1),
        .grant(grant), .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_LAT(LAT_B)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(1'b0), .addr0(b_addr0), .wdata0(32'd0), .ready0(b_ready0),
        .rdata0(b_rdata0),
        .req1(1'b0), .we1(1'b0), .addr1(32'd0), .wdata1(32'd0), .ready1(b_ready1),
        .rdata1(b_rdata1),
        .grant(b_grant), .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h0100_0193 + 32'h5A5A_0000;
    endfunction

    // Memories with a fixed read pipeline of LAT / LAT_B cycles.
    logic [31:0] mem [1024];
    logic [31:0] pipe [LAT];
    logic [31:0] b_mem [1024];
    logic [31:0] b_pipe [LAT_B];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i]   <= init_word(i);
                b_mem[i] <= init_word(i);
            end
            mem_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        b_pipe[0] <= b_mem[b_mem_addr];
        for (int i = 1; i < LAT_B; i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign mem_rdata   = pipe[LAT-1];
    assign b_mem_rdata = b_pipe[LAT_B-1];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [9:0]  word;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    txn_t        iss_q[$];
    txn_t        rsp_q[$];
    int          served[$];
    logic [31:0] ref_mem [1024];
    int          cyc   = 0;
    int          cnt_m = 0;
    int          sel_m = 0;
    bit          last_m = 1'b1;

    // Reference: one access occupies LAT+3 cycles from the sampling edge to the next one.
    initial begin
        txn_t t;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                cnt_m  = 0;
                last_m = 1'b1;
                iss_q.delete();
                rsp_q.delete();
            end else begin
                cyc++;
                if (cnt_m > 0) begin
                    cnt_m--;
                end else if (req0 || req1) begin
                    sel_m  = (req0 && req1) ? (last_m ? 0 : 1) : (req1 ? 1 : 0);
                    last_m = (sel_m == 1);
                    cnt_m  = LAT + 2;
                    t.port = sel_m;
                    t.we   = (sel_m == 1) ? we1 : we0;
                    t.word = 10'(((sel_m == 1) ? addr1 : addr0) / 4 % 1024);
                    t.data = (sel_m == 1) ? wdata1 : wdata0;
                    t.cyc  = cyc;
                    iss_q.push_back(t);
                    if (t.we) ref_mem[t.word] = t.data;
                    t.data = ref_mem[t.word];
                    t.cyc  = cyc + LAT + 1;
                    rsp_q.push_back(t);
                end
            end
        end
    end

    // Monitor
    initial begin
        txn_t        t;
        bit          exp_en, exp_rdy;
        bit          known [2];
        logic [31:0] last_rd [2];
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int q = 0; q < 2; q++) begin
                    known[q]   = 1'b1;
                    last_rd[q] = 32'd0;
                end
            end else begin
                check("busy", busy, cnt_m > 0);
                check("grant", grant, (cnt_m == 0) ? 2'b00 : ((sel_m == 1) ? 2'b10 : 2'b01));
                exp_en = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
                check("mem_en", mem_en, exp_en);
                if (exp_en) begin
                    t = iss_q.pop_front();
                    check("mem_addr", mem_addr, t.word);
                    check("mem_we", mem_we, t.we);
                    if (t.we) check("mem_wdata", mem_wdata, t.data);
                end
                exp_rdy = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
                check("ready_any", ready0 | ready1, exp_rdy);
                t.port = -1;
                if (exp_rdy) begin
                    t = rsp_q.pop_front();
                    served.push_back(t.port);
                    check("ready_port", {ready1, ready0}, (t.port == 1) ? 2'b10 : 2'b01);
                    if (!t.we) check("rdata", (t.port == 1) ? rdata1 : rdata0, t.data);
                    known[t.port]   = !t.we;
                    last_rd[t.port] = t.data;
                end
                for (int q = 0; q < 2; q++) begin
                    if (q != t.port && known[q])
                        check("rdata_hold", (q == 1) ? rdata1 : rdata0, last_rd[q]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the ready cycle.
    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit keep);
        bit got = 1'b0;
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? ready0 : ready1;
        end
        check("ready_timeout", got, 1'b1);
        if (!keep) begin
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
        end
    endtask

    task automatic port_loop(input int p, input int n);
        bit keep;
        for (int k = 0; k < n; k++) begin
            keep = 1'($urandom_range(0, 1));
            drive(p, 1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
                  32'($urandom_range(0, 3)), $urandom, keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt, rdy_cnt, first_en, rdy_at;
        logic [31:0] got;
        bit seen;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        b_req0 = 0; b_addr0 = 0;

        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", {ready1, ready0}, 2'b00);
        check("rst_mem_en", {mem_en, mem_we}, 2'b00);
        check("rst_mem_addr", mem_addr, 10'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Both ports held: grants must alternate starting with port 0.
        served.delete();
        fork
            begin drive(0, 1'b0, 32'd4, 32'd0, 1'b1); drive(0, 1'b0, 32'd8, 32'd0, 1'b0); end
            begin drive(1, 1'b0, 32'd12, 32'd0, 1'b1); drive(1, 1'b0, 32'd16, 32'd0, 1'b0); end
        join
        check("rr_count", served.size(), 4);
        for (int i = 0; i < 4 && i < served.size(); i++) check("rr_order", served[i], i % 2);

        // Preload word 20 from the debug port, read it from the CPU port.
        drive(1, 1'b1, 32'h50, 32'h0000_0055, 1'b0);
        drive(0, 1'b0, 32'h50, 32'd0, 1'b0);
        check("preload_rdata0", rdata0, 32'h0000_0055);

        drive(1, 1'b1, 32'd84, 32'hDEAD_BEEF, 1'b0);
        drive(0, 1'b0, 32'd84, 32'd0, 1'b0);
        check("debug_wr_rdata0", rdata0, 32'hDEAD_BEEF);

        // Upper bits ignored; addr0 changed after the grant must not matter.
        fork
            drive(0, 1'b0, 32'h0000_1004, 32'd0, 1'b0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = (grant != 2'b00);
                end
                check("wrap_grant_seen", seen, 1'b1);
                #1 addr0 = 32'h0000_2008;
            end
        join
        check("wrap_rdata0", rdata0, init_word(1));

        // MEM_LAT=3 instance: ready 4 cycles after the issue cycle, single mem_en cycle.
        @(negedge clk);
        b_req0 = 1'b1; b_addr0 = 32'd28;
        en_cnt = 0; rdy_cnt = 0; first_en = -1; rdy_at = -1; got = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b_mem_en) begin
                en_cnt++;
                if (first_en < 0) first_en = k;
                check("lat3_mem_addr", b_mem_addr, 10'd7);
            end
            if (b_ready0) begin
                rdy_cnt++;
                if (rdy_at < 0) begin rdy_at = k; got = b_rdata0; end
                b_req0 = 1'b0;
            end
        end
        check("lat3_en_cycles", en_cnt, 1);
        check("lat3_first_en", first_en, 0);
        check("lat3_ready_at", rdy_at, LAT_B + 1);
        check("lat3_ready_cnt", rdy_cnt, 1);
        check("lat3_rdata", got, init_word(7));

        fork
            port_loop(0, 30);
            port_loop(1, 30);
        join

        // Reset during WAIT aborts the access with no ready pulse.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_en;
        end
        check("abort_issue_seen", seen, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_grant", grant, 2'b00);
        check("abort_mem_en", mem_en, 1'b0);
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ready", {ready1, ready0}, 2'b00);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        drive(1, 1'b0, 32'h44, 32'd0, 1'b0);
        check("post_rst_rdata1", rdata1, ref_mem[17]);

        repeat (6) @(negedge clk);
        check("iss_q_empty", iss_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
